i2c_line_filter: RTL and testbench

Receive-side conditioning block for the I2C SCL/SDA lines. It is the input-direction counterpart of the transmit-side fixed SDA delay line. It synchronises both raw bus inputs and rejects glitches with a per-line stability counter. It also produces single-cycle SCL edge strobes, START and STOP condition strobes, and a bus-busy flag. The I2C master/slave FSMs consume these outputs instead of raw pad inputs.

---
 rtl/i2c_line_filter.sv | 95 +++++++++
 tb/tb_i2c_line_filter.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_line_filter.sv
// Receive-side SCL/SDA conditioning: synchroniser, per-line stability filter,
// SCL edge strobes, START/STOP strobes and bus-busy flag.
module i2c_line_filter #(
    parameter int SYNC_STAGES = 2,
    parameter int FILT_LEN    = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic scl_in,
    input  logic sda_in,
    output logic scl_filt,
    output logic sda_filt,
    output logic scl_rise,
    output logic scl_fall,
    output logic start_det,
    output logic stop_det,
    output logic bus_busy
);
    localparam int             CW      = $clog2(FILT_LEN + 1);
    localparam logic [CW-1:0]  CNT_MAX = CW'(FILT_LEN - 1);

    // Line index 0 is SCL, 1 is SDA.
    logic [1:0] w_raw;
    logic [1:0] w_sync;
    logic [1:0] w_filt;
    logic [1:0] w_upd;

    assign w_raw = {sda_in, scl_in};

    for (genvar g = 0; g < 2; g++) begin : g_line
        logic [SYNC_STAGES-1:0] r_sync;
        logic [CW-1:0]          r_cnt;
        logic                   r_filt;

        always_ff @(posedge clk) begin
            if (rst) r_sync <= '1;
            else     r_sync <= {r_sync[SYNC_STAGES-2:0], w_raw[g]};
        end

        assign w_sync[g] = r_sync[SYNC_STAGES-1];
        assign w_filt[g] = r_filt;
        assign w_upd[g]  = (w_sync[g] != r_filt) && (r_cnt == CNT_MAX);

        // Any sample back at the filtered level discards the partial count.
        always_ff @(posedge clk) begin
            if (rst) begin
                r_cnt  <= '0;
                r_filt <= 1'b1;
            end else if (w_sync[g] == r_filt) begin
                r_cnt  <= '0;
            end else if (w_upd[g]) begin
                r_cnt  <= '0;
                r_filt <= w_sync[g];
            end else begin
                r_cnt  <= r_cnt + 1'b1;
            end
        end
    end

    // SDA moving while SCL is steady high; a coincident SCL edge wins.
    logic w_sda_cond;
    logic w_start;
    logic w_stop;

    assign w_sda_cond = w_upd[1] && !w_upd[0] && w_filt[0];
    assign w_start    = w_sda_cond && !w_sync[1];
    assign w_stop     = w_sda_cond &&  w_sync[1];

    logic r_scl_rise, r_scl_fall, r_start, r_stop, r_busy;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_scl_rise <= 1'b0;
            r_scl_fall <= 1'b0;
            r_start    <= 1'b0;
            r_stop     <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            r_scl_rise <= w_upd[0] &&  w_sync[0];
            r_scl_fall <= w_upd[0] && !w_sync[0];
            r_start    <= w_start;
            r_stop     <= w_stop;
            if (w_start)     r_busy <= 1'b1;
            else if (w_stop) r_busy <= 1'b0;
        end
    end

    assign scl_filt  = w_filt[0];
    assign sda_filt  = w_filt[1];
    assign scl_rise  = r_scl_rise;
    assign scl_fall  = r_scl_fall;
    assign start_det = r_start;
    assign stop_det  = r_stop;
    assign bus_busy  = r_busy;
endmodule

// File: tb/tb_i2c_line_filter.sv
// Bench for i2c_line_filter: directed scenarios plus random line activity,
// checked every cycle against a sample-history reference model.
module tb_i2c_line_filter;
    localparam int SS = 2;
    localparam int FL = 8;
    localparam int L  = SS + FL;

    logic clk = 1'b0;
    logic rst, scl_in, sda_in;
    logic scl_filt, sda_filt, scl_rise, scl_fall, start_det, stop_det, bus_busy;

    always #5 clk = ~clk;

    i2c_line_filter #(.SYNC_STAGES(SS), .FILT_LEN(FL)) dut (
        .clk(clk), .rst(rst), .scl_in(scl_in), .sda_in(sda_in),
        .scl_filt(scl_filt), .sda_filt(sda_filt),
        .scl_rise(scl_rise), .scl_fall(scl_fall),
        .start_det(start_det), .stop_det(stop_det), .bus_busy(bus_busy)
    );

    logic [6:0] o_vec;
    assign o_vec = {scl_filt, sda_filt, scl_rise, scl_fall, start_det, stop_det, bus_busy};

    // Model: the filter sees the raw sample from SS edges ago; a line flips
    // once the FL most recent such samples all disagree with its level.
    bit        qs[L];
    bit        qd[L];
    bit        mf_s, mf_d, m_busy;
    bit [6:0]  m_vec;
    bit [1:0]  stim[$];
    int        n_cmp = 0;
    int        n_bad = 0;

    task automatic model_step(input bit s, input bit d, input bit r);
        bit as, ad, ns, nd, st, sp;
        if (r) begin
            for (int i = 0; i < L; i++) begin qs[i] = 1'b1; qd[i] = 1'b1; end
            mf_s = 1'b1; mf_d = 1'b1; m_busy = 1'b0;
            m_vec = 7'b1100000;
        end else begin
            for (int i = 0; i < L - 1; i++) begin qs[i] = qs[i+1]; qd[i] = qd[i+1]; end
            qs[L-1] = s; qd[L-1] = d;
            as = 1'b1; ad = 1'b1;
            for (int i = 0; i < FL; i++) begin
                if (qs[i] == mf_s) as = 1'b0;
                if (qd[i] == mf_d) ad = 1'b0;
            end
            ns = as ? ~mf_s : mf_s;
            nd = ad ? ~mf_d : mf_d;
            st = ad && !as && mf_s && !nd;
            sp = ad && !as && mf_s &&  nd;
            if (st)      m_busy = 1'b1;
            else if (sp) m_busy = 1'b0;
            m_vec = {ns, nd, as && ns, as && !ns, st, sp, m_busy};
            mf_s = ns; mf_d = nd;
        end
    endtask

    task automatic step(input bit s, input bit d, input bit r);
        rst = r; scl_in = s; sda_in = d;
        model_step(s, d, r);
        @(posedge clk);
        #1;
    endtask

    task automatic add(input bit s, input bit d, input int n);
        repeat (n) stim.push_back({s, d});
    endtask

    task automatic test_reset;
        int f_scl, f_sda;
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0, 1'b1);
            n_cmp++;
            if (o_vec !== 7'b1100000) begin
                n_bad++;
                $display("FAIL reset_hold cyc=%0d got=%b want=%b", i, o_vec, 7'b1100000);
            end
        end
        stim.delete();
        add(0, 0, 20); add(1, 1, 20);
        f_scl = -1; f_sda = -1;
        foreach (stim[i]) begin
            step(stim[i][1], stim[i][0], 1'b0);
            n_cmp++;
            if (o_vec !== m_vec) begin
                n_bad++;
                $display("FAIL reset_release cyc=%0d got=%b want=%b", i + 1, o_vec, m_vec);
            end
            if (!scl_filt && f_scl < 0) f_scl = i + 1;
            if (!sda_filt && f_sda < 0) f_sda = i + 1;
        end
        n_cmp++;
        if (f_scl !== 10) begin n_bad++; $display("FAIL reset_scl_latency got=%0d want=10", f_scl); end
        n_cmp++;
        if (f_sda !== 10) begin n_bad++; $display("FAIL reset_sda_latency got=%0d want=10", f_sda); end
    endtask

    task automatic test_start_stop;
        int e_start, e_stop, busy_at_start, busy_at_stop;
        stim.delete();
        add(1, 0, 50); add(1, 1, 30);
        e_start = -1; e_stop = -1; busy_at_start = -1; busy_at_stop = -1;
        foreach (stim[i]) begin
            step(stim[i][1], stim[i][0], 1'b0);
            n_cmp++;
            if (o_vec !== m_vec) begin
                n_bad++;
                $display("FAIL start_stop cyc=%0d got=%b want=%b", i + 1, o_vec, m_vec);
            end
            if (start_det && e_start < 0) begin e_start = i + 1; busy_at_start = bus_busy; end
            if (stop_det  && e_stop  < 0) begin e_stop  = i + 1; busy_at_stop  = bus_busy; end
        end
        n_cmp++;
        if (e_start !== 10) begin n_bad++; $display("FAIL start_edge got=%0d want=10", e_start); end
        n_cmp++;
        if (busy_at_start !== 1) begin n_bad++; $display("FAIL busy_on_start got=%0d want=1", busy_at_start); end
        n_cmp++;
        if (e_stop !== 60) begin n_bad++; $display("FAIL stop_edge got=%0d want=60", e_stop); end
        n_cmp++;
        if (busy_at_stop !== 0) begin n_bad++; $display("FAIL busy_on_stop got=%0d want=0", busy_at_stop); end
    endtask

    task automatic test_glitch;
        int e_fall, e_rise;
        stim.delete();
        add(0, 1, 7); add(1, 1, 20); add(0, 1, 8); add(1, 1, 20);
        e_fall = -1; e_rise = -1;
        foreach (stim[i]) begin
            step(stim[i][1], stim[i][0], 1'b0);
            n_cmp++;
            if (o_vec !== m_vec) begin
                n_bad++;
                $display("FAIL glitch cyc=%0d got=%b want=%b", i + 1, o_vec, m_vec);
            end
            if (scl_fall && e_fall < 0) e_fall = i + 1;
            if (scl_rise && e_rise < 0) e_rise = i + 1;
        end
        n_cmp++;
        if (e_fall !== 37) begin n_bad++; $display("FAIL glitch_fall_edge got=%0d want=37", e_fall); end
        n_cmp++;
        if (e_rise !== 45) begin n_bad++; $display("FAIL glitch_rise_edge got=%0d want=45", e_rise); end
    endtask

    task automatic test_repeated_start;
        int n_start, n_stop, busy_drop;
        bit seen;
        stim.delete();
        add(1, 0, 20); add(0, 0, 15); add(0, 1, 15); add(1, 1, 15);
        add(1, 0, 20); add(0, 0, 15); add(1, 0, 15); add(1, 1, 20);
        n_start = 0; n_stop = 0; busy_drop = 0; seen = 1'b0;
        foreach (stim[i]) begin
            step(stim[i][1], stim[i][0], 1'b0);
            n_cmp++;
            if (o_vec !== m_vec) begin
                n_bad++;
                $display("FAIL rep_start cyc=%0d got=%b want=%b", i + 1, o_vec, m_vec);
            end
            if (start_det) begin n_start++; seen = 1'b1; end
            if (stop_det) n_stop++;
            if (seen && n_stop == 0 && !bus_busy) busy_drop++;
        end
        n_cmp++;
        if (n_start !== 2) begin n_bad++; $display("FAIL rep_start_count got=%0d want=2", n_start); end
        n_cmp++;
        if (n_stop !== 1) begin n_bad++; $display("FAIL rep_stop_count got=%0d want=1", n_stop); end
        n_cmp++;
        if (busy_drop !== 0) begin n_bad++; $display("FAIL rep_busy_gap got=%0d want=0", busy_drop); end
    endtask

    task automatic test_simultaneous;
        int n_rise, n_fall, n_ss;
        stim.delete();
        add(1, 1, 15); add(0, 0, 15); add(1, 1, 15);
        n_rise = 0; n_fall = 0; n_ss = 0;
        foreach (stim[i]) begin
            step(stim[i][1], stim[i][0], 1'b0);
            n_cmp++;
            if (o_vec !== m_vec) begin
                n_bad++;
                $display("FAIL simultaneous cyc=%0d got=%b want=%b", i + 1, o_vec, m_vec);
            end
            if (scl_rise) n_rise++;
            if (scl_fall) n_fall++;
            if (start_det || stop_det) n_ss++;
        end
        n_cmp++;
        if (n_fall !== 1 || n_rise !== 1) begin
            n_bad++; $display("FAIL simul_edges got=%0d/%0d want=1/1", n_fall, n_rise);
        end
        n_cmp++;
        if (n_ss !== 0) begin n_bad++; $display("FAIL simul_start_stop got=%0d want=0", n_ss); end
    endtask

    task automatic test_data;
        int n_tog, n_sda_chg, n_ss;
        bit lvl, prev;
        stim.delete();
        add(0, 1, 15);
        lvl = 1'b1;
        n_tog = 6;
        for (int k = 0; k < n_tog; k++) begin
            lvl = ~lvl;
            add(0, lvl, $urandom_range(20, 8));
        end
        add(0, 1, 15); add(1, 1, 15);
        n_sda_chg = 0; n_ss = 0; prev = sda_filt;
        foreach (stim[i]) begin
            step(stim[i][1], stim[i][0], 1'b0);
            n_cmp++;
            if (o_vec !== m_vec) begin
                n_bad++;
                $display("FAIL data cyc=%0d got=%b want=%b", i + 1, o_vec, m_vec);
            end
            if (sda_filt !== prev) n_sda_chg++;
            prev = sda_filt;
            if (start_det || stop_det) n_ss++;
        end
        n_cmp++;
        if (n_ss !== 0) begin n_bad++; $display("FAIL data_start_stop got=%0d want=0", n_ss); end
        n_cmp++;
        if (n_sda_chg !== n_tog) begin n_bad++; $display("FAIL data_sda_changes got=%0d want=%0d", n_sda_chg, n_tog); end
    endtask

    task automatic test_reset_mid;
        int f_scl;
        stim.delete();
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 2; i++) step(1'b0, 1'b1, 1'b1);
        n_cmp++;
        if (o_vec !== m_vec) begin n_bad++; $display("FAIL reset_mid_hold got=%b want=%b", o_vec, m_vec); end
        add(0, 1, 15); add(1, 1, 15);
        f_scl = -1;
        foreach (stim[i]) begin
            step(stim[i][1], stim[i][0], 1'b0);
            n_cmp++;
            if (o_vec !== m_vec) begin
                n_bad++;
                $display("FAIL reset_mid cyc=%0d got=%b want=%b", i + 1, o_vec, m_vec);
            end
            if (!scl_filt && f_scl < 0) f_scl = i + 1;
        end
        n_cmp++;
        if (f_scl !== 10) begin n_bad++; $display("FAIL reset_mid_latency got=%0d want=10", f_scl); end
    endtask

    task automatic test_random;
        bit s, d;
        int hs, hd;
        s = 1'b1; d = 1'b1; hs = 0; hd = 0;
        for (int i = 0; i < 4000; i++) begin
            if (hs == 0) begin s = ~s; hs = $urandom_range(14, 1); end
            if (hd == 0) begin d = ~d; hd = $urandom_range(14, 1); end
            hs--; hd--;
            step(s, d, ($urandom_range(999, 0) == 0));
            n_cmp++;
            if (o_vec !== m_vec) begin
                n_bad++;
                $display("FAIL random cyc=%0d got=%b want=%b", i, o_vec, m_vec);
            end
        end
    endtask

    initial begin
        rst = 1'b1; scl_in = 1'b1; sda_in = 1'b1;
        test_reset;
        test_start_stop;
        test_glitch;
        test_repeated_start;
        test_simultaneous;
        test_data;
        test_reset_mid;
        test_random;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
